fp32_mac_core: RTL and testbench
================================

Name: fp32_mac_core

Overview:
- Sits directly downstream of the 12-byte fp32 UART receiver and upstream of the fp32 UART transmitter.
- Captures one 96-bit operand frame {C, B, A} when the receiver's valid rises and computes R = A*B + C in IEEE-754 single precision.
- Uses a multi-cycle FSM to do the computation.
- Presents the 32-bit result to the TX stage through a valid/ready handshake.

Parameters:
- NAN_CANON, 32'h7FC0_0000, bit pattern emitted for any NaN result.

Ports:
- CLK_I  input  1  system clock
- RSTL_I  input  1  reset, asynchronous, active-low
- RX_VALID_I  input  1  frame-valid from the receiver; level, stays high for many cycles after a frame completes
- RX_DATA_I  input  96  operand frame from the receiver
- RX_READY_O  input-facing output  1  high when the block can accept a new frame (state IDLE)
- MAC_VALID_O  output  1  result valid
- MAC_DATA_O  output  32  result R
- MAC_READY_I  input  1  TX stage accepts the result
- DROP_O  output  1  one-cycle pulse when a frame is ignored because the block is busy

Behaviour:
- Operand map: A = RX_DATA_I[31:0], B = RX_DATA_I[63:32], C = RX_DATA_I[95:64]. Byte k of the UART stream occupies bits [8k+7:8k], LSB first.
- Reset: state=IDLE; MAC_VALID_O=0; MAC_DATA_O=0; DROP_O=0; RX_READY_O=1; rx_valid_d=0; operand registers=0.
- Frame detect: rising edge only (RX_VALID_I & ~rx_valid_d, rx_valid_d registered). A held-high level never retriggers.
- Edge while state!=IDLE: frame discarded, DROP_O=1 for exactly one cycle, computation in progress unaffected.
- FSM: IDLE -> MUL -> MRND -> ALIGN -> ADD -> NORM -> RND -> OUT -> IDLE. One cycle per state except OUT.
  - IDLE: on edge, register A/B/C; next MUL.
  - MUL: unpack fields and form the exact 48-bit mantissa product. Exponent sum = eA + eB - 127.
  - MRND: normalise the product and round to fp32 with round-to-nearest-even (RNE). Call the result P. Arithmetic is non-fused: P is rounded before the add.
  - ALIGN: swap so |X| >= |Y|. Right-shift the smaller mantissa by the exponent difference with guard/round/sticky. A difference >= 27 collapses to sticky only.
  - ADD: add or subtract the aligned 27-bit mantissas (+1 carry bit).
  - NORM: leading-zero count and shift. A carry-out shifts right by 1 and increments the exponent.
  - RND: RNE on guard/round/sticky. Mantissa overflow after rounding increments the exponent.
  - OUT: MAC_VALID_O=1 and MAC_DATA_O stable; hold until MAC_READY_I=1 is sampled. On that edge MAC_VALID_O->0 and next IDLE.
- Latency: the edge is seen in IDLE at cycle N, and MAC_VALID_O rises at cycle N+7. MAC_READY_I already high gives a 1-cycle valid pulse.
- RX_READY_O = (state==IDLE).
- Subnormal handling: subnormal inputs are treated as signed zero. Subnormal or underflowing results flush to signed zero.
- Overflow: exponent >= 255 after rounding gives a signed infinity.
- Specials, checked in MUL/ALIGN and bypassing arithmetic:
  - Any NaN operand -> NAN_CANON.
  - Inf*0 -> NAN_CANON.
  - (+Inf) + (-Inf) -> NAN_CANON.
  - Inf product or Inf C -> that signed infinity.
- Zero sign:
  - An exact zero sum from opposite signs gives +0.
  - (-0) + (-0) gives -0.
  - Zero product sign = sA ^ sB.
- Reset asserted mid-operation: immediate return to reset values; partial results are lost and no output is produced.

Test Plan:
- A=0x40000000 (2.0), B=0x40400000 (3.0), C=0x3F800000 (1.0), one RX_VALID_I rise, MAC_READY_I=1 -> MAC_DATA_O=0x40E00000, MAC_VALID_O high exactly 7 cycles after the edge, for 1 cycle.
- A=0x3F800000, B=0x3F800000, C=0xBF800000 -> 0x00000000 (+0). Then A=0x80000000, B=0x3F800000, C=0x80000000 -> 0x80000000.
- Specials:
  - A=0x7F800000, B=0x00000000, C=0x3F800000 -> 0x7FC00000.
  - A=0x7F7FFFFF, B=0x40000000, C=0 -> 0x7F800000.
  - A=0x00000001 (subnormal), B=0x3F800000, C=0x3F800000 -> 0x3F800000.
- Rounding: A=0x3F800001, B=0x3F800001, C=0 -> 0x3F800002 (RNE of product). A=0x4B800000 (2^24), B=0x3F800000, C=0x3F800000 -> 0x4B800000 (tie to even).
- Handshake: hold MAC_READY_I=0 for 20 cycles -> MAC_VALID_O/MAC_DATA_O stable for the whole window. Keep RX_VALID_I high throughout -> no second computation. A new RX_VALID_I rise while in OUT -> DROP_O pulses 1 cycle and MAC_DATA_O is unchanged.
- Reset: assert RSTL_I low during ADD -> all outputs 0 and RX_READY_O=1 asynchronously. After release, a fresh frame computes correctly.

Source files
------------

// File: rtl/fp32_mac_core.sv
// fp32_mac_core: non-fused IEEE-754 single-precision R = A*B + C between the UART RX and TX stages
module fp32_mac_core #(
  parameter logic [31:0] NAN_CANON = 32'h7FC0_0000
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic        RX_VALID_I,
  input  logic [95:0] RX_DATA_I,
  output logic        RX_READY_O,
  output logic        MAC_VALID_O,
  output logic [31:0] MAC_DATA_O,
  input  logic        MAC_READY_I,
  output logic        DROP_O
);
  localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, MRND = 3'd2, ALIGN = 3'd3;
  localparam logic [2:0] ADD = 3'd4, NORM = 3'd5, RND = 3'd6, OUT = 3'd7;
  logic [2:0] state;
  logic rx_valid_d, rx_edge;
  logic [31:0] a_r, b_r, c_r, p_r, spec_w;
  logic m_nan, m_inf, m_zero, m_sign, spec_r, x_s, sub_r, nz_r;
  logic signed [9:0] m_exp, ne_r;
  logic [47:0] m_prod;
  logic [7:0] x_e;
  logic [26:0] x_al, y_al, n_r;
  logic [27:0] sum_r;
  function automatic logic is_nan(input logic [31:0] x);
    return &x[30:23] && |x[22:0];
  endfunction
  assign rx_edge = RX_VALID_I & ~rx_valid_d;
  assign RX_READY_O = state == IDLE;
  logic a_z, b_z, a_inf, b_inf;
  assign a_z = a_r[30:23] == 8'h00;
  assign b_z = b_r[30:23] == 8'h00;
  assign a_inf = &a_r[30:23] && a_r[22:0] == 23'h0;
  assign b_inf = &b_r[30:23] && b_r[22:0] == 23'h0;
  // product rounding: the 48-bit product has its leading one at bit 47 or 46
  logic hi;
  logic [23:0] pm;
  logic pg, ps;
  logic [24:0] pr;
  logic signed [9:0] pe;
  logic [31:0] p_word;
  assign hi = m_prod[47];
  assign pm = hi ? m_prod[47:24] : m_prod[46:23];
  assign pg = hi ? m_prod[23] : m_prod[22];
  assign ps = hi ? |m_prod[22:0] : |m_prod[21:0];
  assign pr = {1'b0, pm} + {24'h0, pg & (ps | pm[0])};
  assign pe = m_exp + $signed({9'h0, hi}) + $signed({9'h0, pr[24]});
  assign p_word = m_inf ? {m_sign, 8'hFF, 23'h0} : m_zero ? {m_sign, 31'h0} :
                  pe >= 10'sd255 ? {m_sign, 8'hFF, 23'h0} : pe <= 10'sd0 ? {m_sign, 31'h0} :
                  {m_sign, pe[7:0], pr[24] ? pr[23:1] : pr[22:0]};
  logic [30:0] c_mag;
  logic swap, p_inf, c_inf;
  logic [31:0] xw, yw;
  logic [23:0] x_m, y_m;
  logic [7:0] d;
  logic [53:0] sh;
  assign c_mag = c_r[30:23] == 8'h00 ? 31'h0 : c_r[30:0];
  assign swap = c_mag > p_r[30:0];
  assign xw = swap ? {c_r[31], c_mag} : p_r;
  assign yw = swap ? p_r : {c_r[31], c_mag};
  assign x_m = {|xw[30:23], xw[22:0]};
  assign y_m = {|yw[30:23], yw[22:0]};
  assign d = xw[30:23] - yw[30:23];
  assign sh = {y_m, 3'b000, 27'h0} >> d;
  assign p_inf = &p_r[30:23];
  assign c_inf = &c_r[30:23];
  logic [4:0] lz;
  logic [26:0] n_c;
  logic signed [9:0] ne_c;
  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (sum_r[i]) lz = 5'(26 - i);
  end
  assign n_c = sum_r[27] ? {sum_r[27:2], |sum_r[1:0]} : sum_r[26:0] << lz;
  assign ne_c = sum_r[27] ? $signed({2'b0, x_e}) + 10'sd1 : $signed({2'b0, x_e}) - $signed({5'b0, lz});
  logic rup;
  logic [24:0] rr;
  logic signed [9:0] re;
  logic [31:0] res;
  assign rup = n_r[2] & (n_r[3] | n_r[1] | n_r[0]);
  assign rr = {1'b0, n_r[26:3]} + {24'h0, rup};
  assign re = ne_r + $signed({9'h0, rr[24]});
  // an exact zero from opposite signs is +0; same-sign zeros keep their sign
  assign res = spec_r ? spec_w : nz_r ? {x_s & ~sub_r, 31'h0} :
               re >= 10'sd255 ? {x_s, 8'hFF, 23'h0} : re <= 10'sd0 ? {x_s, 31'h0} :
               {x_s, re[7:0], rr[24] ? rr[23:1] : rr[22:0]};
  always_ff @(posedge CLK_I or negedge RSTL_I)
    if (!RSTL_I) begin
      state <= IDLE;
      rx_valid_d <= 1'b0;
      DROP_O <= 1'b0;
      MAC_VALID_O <= 1'b0;
      MAC_DATA_O <= 32'h0;
      {a_r, b_r, c_r, p_r, spec_w} <= '0;
      {m_nan, m_inf, m_zero, m_sign, spec_r, x_s, sub_r, nz_r} <= '0;
      m_exp <= '0;
      ne_r <= '0;
      m_prod <= '0;
      x_e <= '0;
      {x_al, y_al, n_r} <= '0;
      sum_r <= '0;
    end else begin
      rx_valid_d <= RX_VALID_I;
      DROP_O <= rx_edge && state != IDLE;
      case (state)
        IDLE: if (rx_edge) begin
          {c_r, b_r, a_r} <= RX_DATA_I;
          state <= MUL;
        end
        MUL: begin
          m_nan <= is_nan(a_r) || is_nan(b_r) || is_nan(c_r) || (a_inf && b_z) || (b_inf && a_z);
          m_inf <= a_inf || b_inf;
          m_zero <= a_z || b_z;
          m_sign <= a_r[31] ^ b_r[31];
          m_exp <= $signed({2'b0, a_r[30:23]}) + $signed({2'b0, b_r[30:23]}) - 10'sd127;
          m_prod <= 48'({|a_r[30:23], a_r[22:0]}) * 48'({|b_r[30:23], b_r[22:0]});
          state <= MRND;
        end
        MRND: begin
          p_r <= p_word;
          state <= ALIGN;
        end
        ALIGN: begin
          spec_r <= m_nan || p_inf || c_inf;
          spec_w <= (m_nan || (p_inf && c_inf && p_r[31] != c_r[31])) ? NAN_CANON : p_inf ? p_r : c_r;
          x_s <= xw[31];
          sub_r <= xw[31] ^ yw[31];
          x_e <= xw[30:23];
          x_al <= {x_m, 3'b000};
          y_al <= d >= 8'd27 ? {26'h0, |y_m} : {sh[53:28], |sh[27:0]};
          state <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? {1'b0, x_al} - {1'b0, y_al} : {1'b0, x_al} + {1'b0, y_al};
          state <= NORM;
        end
        NORM: begin
          n_r <= n_c;
          ne_r <= ne_c;
          nz_r <= sum_r == 28'h0;
          state <= RND;
        end
        RND: begin
          MAC_DATA_O <= res;
          MAC_VALID_O <= 1'b1;
          state <= OUT;
        end
        default: if (MAC_READY_I) begin
          MAC_VALID_O <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fp32_mac_core.sv
// tb_fp32_mac_core: scoreboard bench for fp32_mac_core with a real-arithmetic reference model
module tb_fp32_mac_core;
  logic        CLK_I = 1'b0;
  logic        RSTL_I = 1'b1;
  logic        RX_VALID_I = 1'b0;
  logic [95:0] RX_DATA_I = '0;
  logic        RX_READY_O;
  logic        MAC_VALID_O;
  logic [31:0] MAC_DATA_O;
  logic        MAC_READY_I = 1'b1;
  logic        DROP_O;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];
  fp32_mac_core dut (
    .CLK_I(CLK_I), .RSTL_I(RSTL_I), .RX_VALID_I(RX_VALID_I), .RX_DATA_I(RX_DATA_I),
    .RX_READY_O(RX_READY_O), .MAC_VALID_O(MAC_VALID_O), .MAC_DATA_O(MAC_DATA_O),
    .MAC_READY_I(MAC_READY_I), .DROP_O(DROP_O)
  );
  always #5 CLK_I = ~CLK_I;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  function automatic real f2r(input logic [31:0] x);
    real m;
    int e;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return x[31] ? -m : m;
  endfunction
  function automatic logic [31:0] r2f(input real v);
    logic s;
    real m, r;
    int e, q;
    s = v < 0.0;
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    m = m * 8388608.0;
    q = $rtoi(m);
    r = m - real'(q);
    if (r > 0.5 || (r == 0.5 && q[0])) q++;
    if (q == 32'h0100_0000) begin q = 32'h0080_0000; e++; end
    e += 127;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction
  function automatic logic [31:0] ref_mac(input logic [31:0] a, b, c);
    logic an, bn, cn, ai, bi, ci, az, bz, cz, pi, pz;
    logic [31:0] p;
    real s;
    an = &a[30:23] && |a[22:0]; bn = &b[30:23] && |b[22:0]; cn = &c[30:23] && |c[22:0];
    ai = &a[30:23] && !an; bi = &b[30:23] && !bn; ci = &c[30:23] && !cn;
    az = a[30:23] == 0; bz = b[30:23] == 0; cz = c[30:23] == 0;
    if (an || bn || cn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
    if (ai || bi) p = {a[31] ^ b[31], 8'hFF, 23'h0};
    else if (az || bz) p = {a[31] ^ b[31], 31'h0};
    else p = r2f(f2r(a) * f2r(b));
    pi = &p[30:23];
    pz = p[30:23] == 0;
    if (pi && ci && p[31] != c[31]) return 32'h7FC0_0000;
    if (pi) return p;
    if (ci) return c;
    if (pz && cz) return {p[31] & c[31], 31'h0};
    if (pz) return c;
    if (cz) return p;
    s = f2r(p) + f2r(c);
    if (s == 0.0) return 32'h0;
    return r2f(s);
  endfunction
  always @(negedge CLK_I)
    if (RSTL_I && MAC_VALID_O && MAC_READY_I) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want none", MAC_DATA_O);
      end else check("mac_data", MAC_DATA_O, exp_q.pop_front());
    end
  task automatic wait_idle(input bit rnd);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK_I); #1;
      if (rnd) MAC_READY_I = $urandom_range(0, 3) != 0;
      done = RX_READY_O;
    end
    check("idle_reached", {31'h0, done}, 32'h1);
  endtask
  task automatic send(input logic [31:0] a, b, c, want, input bit rnd);
    RX_DATA_I = {c, b, a};
    RX_VALID_I = 1'b1;
    exp_q.push_back(want);
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    RX_VALID_I = 1'b0;
    wait_idle(rnd);
  endtask
  logic [31:0] dir [18][4] = '{
    '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000},
    '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000},
    '{32'h7F7FFFFF, 32'h40000000, 32'h00000000, 32'h7F800000},
    '{32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3F800000},
    '{32'h3F800001, 32'h3F800001, 32'h00000000, 32'h3F800002},
    '{32'h4B800000, 32'h3F800000, 32'h3F800000, 32'h4B800000},
    '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h7FC00000},
    '{32'h3F800000, 32'h3F800000, 32'h7F800001, 32'h7FC00000},
    '{32'h3F800000, 32'h3F800000, 32'h2B800000, 32'h3F800000},
    '{32'h3F800001, 32'h3F800000, 32'h33800000, 32'h3F800002},
    '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000},
    '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'hFF800000},
    '{32'h80800000, 32'h3F000000, 32'h80000000, 32'h80000000},
    '{32'h3F800000, 32'h3F800000, 32'hFF800000, 32'hFF800000},
    '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000},
    '{32'h40000000, 32'h40400000, 32'hC0C00000, 32'h00000000},
    '{32'hBF800000, 32'h3F800000, 32'h00000000, 32'hBF800000}
  };
  initial begin
    bit seen;
    #1 RSTL_I = 1'b0;
    #2;
    check("rst_valid", {31'h0, MAC_VALID_O}, 32'h0);
    check("rst_data", MAC_DATA_O, 32'h0);
    check("rst_drop", {31'h0, DROP_O}, 32'h0);
    check("rst_ready", {31'h0, RX_READY_O}, 32'h1);
    repeat (3) @(posedge CLK_I);
    #1 RSTL_I = 1'b1;
    @(posedge CLK_I); #1;
    RX_DATA_I = {32'h3F800000, 32'h40400000, 32'h40000000};
    RX_VALID_I = 1'b1;
    exp_q.push_back(32'h40E00000);
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK_I); #1;
      if (i == 2) RX_VALID_I = 1'b0;
      check($sformatf("lat_valid_%0d", i), {31'h0, MAC_VALID_O}, {31'h0, i == 7});
      check($sformatf("lat_ready_%0d", i), {31'h0, RX_READY_O}, {31'h0, i == 8});
    end
    for (int i = 0; i < 18; i++) send(dir[i][0], dir[i][1], dir[i][2], dir[i][3], 1'b0);
    MAC_READY_I = 1'b0;
    RX_DATA_I = {32'h3F800000, 32'h40400000, 32'h40000000};
    RX_VALID_I = 1'b1;
    exp_q.push_back(32'h40E00000);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLK_I); #1;
      seen = MAC_VALID_O;
    end
    check("hs_valid_seen", {31'h0, seen}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) RX_VALID_I = 1'b0;
      if (i == 6) begin
        RX_VALID_I = 1'b1;
        RX_DATA_I = {32'h0, 32'h3F800000, 32'h3F800000};
      end
      @(posedge CLK_I); #1;
      check("hs_valid", {31'h0, MAC_VALID_O}, 32'h1);
      check("hs_data", MAC_DATA_O, 32'h40E00000);
      check("hs_drop", {31'h0, DROP_O}, {31'h0, i == 6});
    end
    MAC_READY_I = 1'b1;
    @(posedge CLK_I); #1;
    check("hs_release", {31'h0, MAC_VALID_O}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK_I); #1;
      check("held_no_retrigger", {31'h0, MAC_VALID_O, RX_READY_O}, 32'h1);
    end
    RX_VALID_I = 1'b0;
    @(posedge CLK_I); #1;
    RX_DATA_I = {32'h3F800000, 32'h40400000, 32'h40000000};
    RX_VALID_I = 1'b1;
    repeat (4) @(posedge CLK_I);
    #1 RX_VALID_I = 1'b0;
    check("mid_ready_busy", {31'h0, RX_READY_O}, 32'h0);
    RSTL_I = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, MAC_VALID_O}, 32'h0);
    check("mid_rst_data", MAC_DATA_O, 32'h0);
    check("mid_rst_ready", {31'h0, RX_READY_O}, 32'h1);
    check("mid_rst_drop", {31'h0, DROP_O}, 32'h0);
    @(posedge CLK_I); #1;
    RSTL_I = 1'b1;
    @(posedge CLK_I); #1;
    send(32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40800000, 1'b0);
    for (int n = 0; n < 300; n++) begin
      int ea, eb, ec;
      logic [31:0] a, b, c;
      ea = $urandom_range(100, 154);
      eb = $urandom_range(100, 154);
      ec = ea + eb - 127 + int'($urandom_range(0, 40)) - 20;
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      c = {1'($urandom), 8'(ec), 23'($urandom)};
      send(a, b, c, ref_mac(a, b, c), 1'b1);
    end
    MAC_READY_I = 1'b1;
    repeat (10) @(posedge CLK_I);
    #1;
    check("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
